// File: rtl/axi3_pkg.sv
// Shared AXI3 read-channel constants, responder FSM states and burst
// legality helper.
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

    // A burst is answered with SLVERR when it is not a 4-byte transfer,
    // uses the reserved burst type, or wraps over a non power-of-two length.
    function automatic logic burst_error(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [3:0] len
    );
        logic bad_wrap_len;
        bad_wrap_len = !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return (size != SIZE_4B) || (burst == 2'b11) || ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO holding {rdata, rresp, rlast}. The occupancy is
// exported so the requester can keep reads in flight without overflow.
module resp_fifo2 #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;

            // Capture a pushed beat into this slot when the write pointer selects it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

    // Advance pointers and track occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/axi3_rd_responder.sv
// AXI3 read responder in front of a synchronous single-port RAM. One AR
// burst at a time is turned into word reads; R beats are streamed through a
// 2-entry FIFO with a bypass so the first beat appears the cycle the RAM
// data returns.
module axi3_rd_responder
    import axi3_pkg::*;
#(
    parameter int BUS_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_WIDTH-1:0]  arid,
    input  logic [ADDR_WIDTH+1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [BUS_WIDTH-1:0]  rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);

    localparam int BEAT_WIDTH = DATA_WIDTH + 3;
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Next word address of a burst; WRAP stays inside the block aligned to len+1
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [1:0]            burst,
        input logic [3:0]            len
    );
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] incr;
        mask = {{(ADDR_WIDTH-4){1'b0}}, len};
        incr = addr + ADDR_ONE;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    endfunction

    rd_state_t             state_reg;
    logic                  arready_reg;
    logic [BUS_WIDTH-1:0]  id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [3:0]            len_reg;
    logic [1:0]            burst_reg;
    logic                  err_reg;
    logic [3:0]            beat_cnt_reg;
    logic [3:0]            lat_cnt_reg;

    // One RAM read may be in flight; its data is valid the following cycle
    logic                  inflight_reg;
    logic                  inflight_last_reg;

    logic [BEAT_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  unused_fifo_full;
    logic                  unused_araddr_lsb;

    logic [BEAT_WIDTH-1:0] bypass_beat;
    logic [BEAT_WIDTH-1:0] head_beat;
    logic [DATA_WIDTH-1:0] bypass_data;
    logic [2:0]            credit_sum;
    logic                  head_valid;
    logic                  pop;
    logic                  issue;

    assign unused_araddr_lsb = ^araddr[1:0];

    resp_fifo2 #(
        .WIDTH(BEAT_WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bypass_beat),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Output selection, handshake and read-credit decision
    always_comb begin
        bypass_data = err_reg ? {DATA_WIDTH{1'b0}} : ram_rddata;
        bypass_beat = {bypass_data, (err_reg ? RESP_SLVERR : RESP_OKAY), inflight_last_reg};
        head_valid  = !fifo_empty || inflight_reg;
        head_beat   = {BEAT_WIDTH{1'b0}};
        if (!fifo_empty) begin
            head_beat = fifo_head;
        end else if (inflight_reg) begin
            head_beat = bypass_beat;
        end
        pop        = head_valid && rready;
        fifo_pop   = pop && !fifo_empty;
        // Returning data goes to the FIFO unless it leaves directly via the bypass
        fifo_push  = inflight_reg && !(fifo_empty && pop);
        credit_sum = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
        issue      = (state_reg == ST_BURST) && (credit_sum < 3'd2);
        ram_en     = issue && !err_reg;
    end

    assign rvalid   = head_valid;
    assign rdata    = head_beat[BEAT_WIDTH-1:3];
    assign rresp    = head_beat[2:1];
    assign rlast    = head_beat[0];
    assign rid      = id_reg;
    assign arready  = arready_reg;
    assign ram_addr = addr_reg;

    // Track the read issued this cycle so its data can be routed next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (beat_cnt_reg == len_reg);
        end
    end

    // Burst control FSM: accept AR, optional wait, issue reads, drain beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            arready_reg  <= 1'b0;
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= 4'd0;
            burst_reg    <= BURST_FIXED;
            err_reg      <= 1'b0;
            beat_cnt_reg <= 4'd0;
            lat_cnt_reg  <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arready_reg && arvalid) begin
                        id_reg       <= arid;
                        addr_reg     <= araddr[ADDR_WIDTH+1:2];
                        len_reg      <= arlen;
                        burst_reg    <= arburst;
                        err_reg      <= burst_error(arsize, arburst, arlen);
                        beat_cnt_reg <= 4'd0;
                        lat_cnt_reg  <= LAT_LOAD;
                        arready_reg  <= 1'b0;
                        state_reg    <= (LATENCY > 0) ? ST_WAIT : ST_BURST;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_reg == 4'd0) begin
                        state_reg <= ST_BURST;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 4'd1;
                    end
                end
                ST_BURST: begin
                    if (issue) begin
                        if (beat_cnt_reg == len_reg) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 4'd1;
                            addr_reg     <= next_addr(addr_reg, burst_reg, len_reg);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && rlast) begin
                        state_reg   <= ST_IDLE;
                        arready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    arready_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_rd_responder.sv
// Scoreboard bench for axi3_rd_responder: AR stimulus pushes the expected
// beats of each burst, an independent monitor pops and compares on every R
// handshake and checks that stalled beats hold steady.
module tb_axi3_rd_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  arid = '0;
    logic [17:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic [31:0] ram_rddata = '0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem [0:65535];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int rmode = 0;
    int ram_en_cnt = 0;
    int beats_popped = 0;
    int hs_cyc = 0;
    int first_rv_cyc = 0;
    int last_cyc = 0;
    bit first_seen = 0;

    axi3_rd_responder #(
        .BUS_WIDTH (4),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rddata(ram_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data valid the cycle after ram_en
    always @(posedge clk) begin
        if (ram_en) ram_rddata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference model: expected beats from burst rules in plain arithmetic
    function automatic void model_burst(input logic [3:0] id, input logic [17:0] addr,
                                        input logic [3:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
        int unsigned start, n, a, base;
        bit err;
        beat_t b;
        start = 32'(addr[17:2]);
        n = 32'(len) + 1;
        err = (size != 3'b010) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(n == 2 || n == 4 || n == 8 || n == 16));
        for (int i = 0; i < int'(n); i++) begin
            if (burst == 2'b00) a = start;
            else if (burst == 2'b10) begin
                base = start - (start % n);
                a = base + ((start % n) + i) % n;
            end else a = (start + i) % 65536;
            b.id = id;
            b.data = err ? 32'd0 : mem[a];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(n) - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_ar(input logic [3:0] id, input logic [17:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int budget = 0;
        bit ok = 0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        first_seen = 0;
        while (!ok && budget < 2000) begin
            if (arready) begin
                hs_cyc = cyc;
                ok = 1;
                @(posedge clk);
                model_burst(id, addr, len, size, burst);
                #1 arvalid = 1'b0;
            end else begin
                budget++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            check("ar_accept_timeout", 64'(ok), 64'(1));
            arvalid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("burst_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    // Wait for the burst to finish, then arready must be back one cycle after rlast
    task automatic finish_burst(input string name);
        wait_done();
        while (cyc <= last_cyc) @(negedge clk);
        check({name, "_arready_after_last"}, 64'(arready), 64'(1));
    endtask

    // rready pattern generator
    initial begin
        int low_left = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    if (low_left > 0) begin
                        rready = 1'b0;
                        low_left--;
                    end else if ($urandom_range(0, 7) == 0) begin
                        low_left = $urandom_range(1, 4);
                        rready = 1'b0;
                    end else rready = ~rready;
                end
                2: rready = ($urandom_range(0, 3) != 0);
                default: rready = 1'b1;
            endcase
        end
    end

    // Monitor: compare every R handshake, check stalled beats hold steady
    initial begin
        bit prev_stall = 0;
        logic [38:0] prev_vals = '0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 0;
            else begin
                if (ram_en) ram_en_cnt++;
                if (prev_stall)
                    check("stall_hold", 64'({rvalid, rid, rdata, rresp, rlast}), 64'({1'b1, prev_vals}));
                if (rvalid) begin
                    if (!first_seen) begin
                        first_seen = 1;
                        first_rv_cyc = cyc;
                    end
                    if (rready) begin
                        check("beat_outstanding", 64'(exp_q.size() > 0), 64'(1));
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check($sformatf("beat%0d", beats_popped),
                                  64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
                        end
                        beats_popped++;
                        if (rlast) begin
                            last_cyc = cyc;
                            check("no_arready_with_rlast", 64'(arready), 64'(0));
                        end
                        prev_stall = 0;
                    end else begin
                        prev_stall = 1;
                        prev_vals = {rid, rdata, rresp, rlast};
                    end
                end else prev_stall = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, bp0, budget;
        logic [1:0] b;
        logic [3:0] l;
        logic [2:0] s;
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 64'(arready), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rlast", 64'(rlast), 64'(0));
        check("rst_rid", 64'(rid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_rresp", 64'(rresp), 64'(0));
        check("rst_ram_en", 64'(ram_en), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("arready_release_cycle", 64'(arready), 64'(0));
        @(negedge clk);
        check("arready_after_release", 64'(arready), 64'(1));

        // INCR 8 beats, words 0x10..0x17 back to back
        rmode = 0;
        en0 = ram_en_cnt;
        send_ar(4'h3, 18'h00040, 4'd7, 3'b010, 2'b01);
        finish_burst("incr8");
        check("incr8_first_latency", 64'(first_rv_cyc - hs_cyc), 64'(2 + LAT));
        check("incr8_consecutive", 64'(last_cyc - first_rv_cyc), 64'(7));
        check("incr8_ram_reads", 64'(ram_en_cnt - en0), 64'(8));

        // WRAP from word 14, len 4: 14,15,12,13
        send_ar(4'h5, 18'h00038, 4'd3, 3'b010, 2'b10);
        finish_burst("wrap4");

        // INCR 16 beats under toggling/bursty backpressure
        rmode = 1;
        send_ar(4'h9, 18'h00100, 4'd15, 3'b010, 2'b01);
        finish_burst("incr16_bp");
        rmode = 0;

        // Bad size: SLVERR beats with zero data and no RAM reads
        en0 = ram_en_cnt;
        send_ar(4'h2, 18'h00080, 4'd3, 3'b001, 2'b01);
        finish_burst("bad_size");
        check("bad_size_ram_reads", 64'(ram_en_cnt - en0), 64'(0));

        // Following OKAY burst is normal
        en0 = ram_en_cnt;
        send_ar(4'h6, 18'h00200, 4'd2, 3'b010, 2'b01);
        finish_burst("okay_after_err");
        check("okay_after_err_ram_reads", 64'(ram_en_cnt - en0), 64'(3));

        // Single beat: latency and rlast
        send_ar(4'h1, 18'h00044, 4'd0, 3'b010, 2'b00);
        finish_burst("single");
        check("single_latency", 64'(first_rv_cyc - hs_cyc), 64'(2 + LAT));
        check("single_one_cycle", 64'(last_cyc - first_rv_cyc), 64'(0));

        // INCR across the top of the word space
        send_ar(4'hA, 18'h3FFF8, 4'd3, 3'b010, 2'b01);
        finish_burst("addr_wrap");

        // Async reset after 3 beats of a 16-beat burst
        bp0 = beats_popped;
        send_ar(4'hC, 18'h00400, 4'd15, 3'b010, 2'b01);
        budget = 0;
        while (beats_popped - bp0 < 3 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        check("mid_reset_beats_seen", 64'(beats_popped - bp0 >= 3), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_reset_rvalid", 64'(rvalid), 64'(0));
        check("mid_reset_ram_en", 64'(ram_en), 64'(0));
        check("mid_reset_arready", 64'(arready), 64'(0));
        check("mid_reset_rlast_rdata", 64'({rlast, rdata}), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        bp0 = beats_popped;
        repeat (20) @(negedge clk);
        check("no_beats_after_reset", 64'(beats_popped - bp0), 64'(0));
        rmode = 2;
        send_ar(4'hD, 18'h00040, 4'd3, 3'b010, 2'b01);
        finish_burst("post_reset");

        // Random bursts against the model with random memory contents
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int k = 0; k < 30; k++) begin
            b = 2'($urandom_range(0, 3));
            l = 4'($urandom_range(0, 15));
            if (b == 2'b10 && $urandom_range(0, 3) != 0) l = 4'((1 << $urandom_range(1, 4)) - 1);
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            send_ar(4'($urandom), 18'($urandom), l, s, b);
        end
        wait_done();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi3_rd_responder.md
# axi3_rd_responder

AXI3 read-channel responder (slave) backed by an external synchronous single-port RAM; the response end of the `axi3_rd_if` protocol that `icache` initiates. Accepts one AR burst at a time, converts it to word-addressed RAM reads and streams R beats with full backpressure support. Used as the memory model behind cache benches and as the on-chip boot/scratch RAM front end.

## Interface
- `BUS_WIDTH`, 4, ID width of the `axi3_rd_if` instance.
- `DATA_WIDTH`, 32, RAM word and R data width; only 32 supported.
- `ADDR_WIDTH`, 16, RAM word-address width; byte address bits `[ADDR_WIDTH+1:2]` select the word.
- `LATENCY`, 0, extra idle cycles inserted between AR handshake and the first RAM read (0..15).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `axi3_rd_if`  slave modport  `axi3_rd_if #(.BUS_WIDTH(BUS_WIDTH))`  AR and R channels (arid, araddr, arlen, arsize, arburst, arvalid/arready; rid, rdata, rresp, rlast, rvalid/rready).
- `ram_en`  out  1  RAM read strobe.
- `ram_addr`  out  ADDR_WIDTH  RAM word address.
- `ram_rddata`  in  DATA_WIDTH  RAM data, valid exactly one cycle after `ram_en`.

## Operation
- FSM states: IDLE, WAIT, BURST, DRAIN.
  - IDLE: `arready`=1; on `arvalid` latch arid, word address, arlen, arburst, error flag; go WAIT if `LATENCY`>0 else BURST.
  - WAIT: count `LATENCY` cycles, then BURST.
  - BURST: issue one RAM read per cycle while credit allows; after issuing beat `arlen`, go DRAIN.
  - DRAIN: wait until last beat handshakes (rvalid & rready & rlast), then IDLE.
- `arready`=0 in every state except IDLE; single outstanding burst.
- Credit rule: issue read when `occupancy + inflight - pop < 2` (2-entry output FIFO, 1 read in flight max). Gives 1 beat/cycle with `rready` held high, no data loss under any `rready` pattern.
- Address sequencing (word granularity, wrap at 2^ADDR_WIDTH words):
  - FIXED (00): same address every beat.
  - INCR (01): +1 per beat.
  - WRAP (10): +1, wrapping inside aligned block of `arlen+1` words; wrap boundary = `addr & ~arlen`.
- Error (SLVERR, rresp=2'b10) for the whole burst if: arsize≠3'b010, arburst=2'b11, or WRAP with arlen ∉ {1,3,7,15}. Erroneous bursts still return `arlen+1` beats, rdata=0, no RAM reads issued; otherwise rresp=OKAY (00).
- `rid` = latched arid on every beat; `rlast`=1 only on beat index `arlen`.
- R outputs stable while `rvalid`=1 and `rready`=0.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, ram_en=0, ram_addr=0; FSM=IDLE. `arready` rises the first cycle after `rst` deasserts.
- AR handshake at cycle T, LATENCY=L: first `ram_en` at T+1+L, first `rvalid` at T+2+L.
- Burst of N beats with `rready`=1: beats on consecutive cycles T+2+L .. T+1+L+N.
- After last-beat handshake at cycle E, `arready`=1 at E+1 (no AR accept in same cycle as rlast).
- Async reset mid-burst: burst aborted, FIFO and in-flight read discarded, all outputs to reset values immediately; no remaining beats are ever emitted.
- `arvalid` while not in IDLE: ignored, not latched.

## Structure
- Shared package (`axi3_pkg`, extend if present): `BURST_FIXED/INCR/WRAP`, `RESP_OKAY/SLVERR`, `SIZE_4B` constants, FSM state enum.
- Sub-module `resp_fifo2`: 2-entry FIFO of {rdata, rresp, rlast}, push/pop/full/empty, async reset; tracks occupancy for credit.
- Top: FSM, latency counter, beat counter (4 bits), address generator.

## Test plan
- INCR araddr=0x0000_0040, arlen=7, rready=1, RAM word i = i → 8 beats rdata 0x10..0x17 on consecutive cycles, rlast on 8th, rresp=00.
- WRAP araddr=0x0000_0038 (word 14), arlen=3 → rdata words 14,15,12,13; rid echoes arid=0x5.
- INCR arlen=15, rready toggling 1/0 every cycle and random bursts of low → all 16 beats in order, no duplicates, R signals stable while stalled.
- arsize=3'b001, arlen=3 → 4 beats rresp=10, rdata=0, ram_en never asserted; next OKAY burst returns correct data.
- LATENCY=3, arlen=0 → single beat, rvalid exactly 5 cycles after AR handshake, rlast=1; arready back 1 cycle after handshake.
- rst asserted at beat 3 of a 16-beat burst → rvalid=0 same cycle, no further beats; new burst after reset returns correct data from beat 0.
